// File: rtl/alu_mc.sv
// -----------------------------------------------------------------------------
// alu_mc -- multi-cycle ALU for the RISC-V execute stage.
//
// Single-cycle ops (ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU) are
// computed combinationally and registered at the accept edge. MUL/MULHU use a
// shift-add multiplier and DIVU/REMU a restoring divider; both run for
// DATA_WIDTH BUSY edges. Operands enter and results leave through valid/ready
// handshakes so the block can stall the pipeline.
//
// DATA_WIDTH must be >= 4 and a power of two.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   ALUop1/ALUop2/ALUctrl are valid
//   in_ready   a new operation is accepted this cycle
//   ALUop1     operand 1
//   ALUop2     operand 2 (low log2(DATA_WIDTH) bits are the shift amount)
//   ALUctrl    operation select
//   out_valid  ALUout/zero hold a result
//   out_ready  consumer takes the result
//   ALUout     registered result
//   zero       ALUout == 0, registered together with ALUout
//   busy       an iterative operation is running
// -----------------------------------------------------------------------------
module alu_mc #(
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] ALUop1,
  input  logic [DATA_WIDTH-1:0] ALUop2,
  input  logic [CTRL_WIDTH-1:0] ALUctrl,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] ALUout,
  output logic                  zero,
  output logic                  busy
);

  localparam int SHW   = $clog2(DATA_WIDTH);
  localparam int CNT_W = SHW + 1;

  localparam logic [CTRL_WIDTH-1:0] OP_ADD   = CTRL_WIDTH'(0);
  localparam logic [CTRL_WIDTH-1:0] OP_SUB   = CTRL_WIDTH'(1);
  localparam logic [CTRL_WIDTH-1:0] OP_AND   = CTRL_WIDTH'(2);
  localparam logic [CTRL_WIDTH-1:0] OP_OR    = CTRL_WIDTH'(3);
  localparam logic [CTRL_WIDTH-1:0] OP_XOR   = CTRL_WIDTH'(4);
  localparam logic [CTRL_WIDTH-1:0] OP_SLL   = CTRL_WIDTH'(5);
  localparam logic [CTRL_WIDTH-1:0] OP_SRL   = CTRL_WIDTH'(6);
  localparam logic [CTRL_WIDTH-1:0] OP_SRA   = CTRL_WIDTH'(7);
  localparam logic [CTRL_WIDTH-1:0] OP_SLT   = CTRL_WIDTH'(8);
  localparam logic [CTRL_WIDTH-1:0] OP_SLTU  = CTRL_WIDTH'(9);
  localparam logic [CTRL_WIDTH-1:0] OP_MUL   = CTRL_WIDTH'(10);
  localparam logic [CTRL_WIDTH-1:0] OP_MULHU = CTRL_WIDTH'(11);
  localparam logic [CTRL_WIDTH-1:0] OP_DIVU  = CTRL_WIDTH'(12);
  localparam logic [CTRL_WIDTH-1:0] OP_REMU  = CTRL_WIDTH'(13);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t                  r_state;
  state_t                  w_state_nx;
  logic [DATA_WIDTH-1:0]   r_aluout;
  logic                    r_zero;
  logic [CNT_W-1:0]        r_cnt;
  logic [CTRL_WIDTH-1:0]   r_op;
  logic [DATA_WIDTH-1:0]   r_hi;   // product high half / partial remainder
  logic [DATA_WIDTH-1:0]   r_lo;   // multiplier then product low / quotient
  logic [DATA_WIDTH-1:0]   r_m;    // multiplicand / divisor

  logic                    w_accept;
  logic                    w_is_iter;
  logic [SHW-1:0]          w_shamt;
  logic [DATA_WIDTH-1:0]   w_single;
  logic                    w_op_is_mul;
  logic [DATA_WIDTH:0]     w_sum;
  logic [DATA_WIDTH:0]     w_rem_sh;
  logic                    w_ge;
  logic [DATA_WIDTH-1:0]   w_diff;
  logic [DATA_WIDTH-1:0]   w_hi_nx;
  logic [DATA_WIDTH-1:0]   w_lo_nx;
  logic [DATA_WIDTH-1:0]   w_iter_res;

  assign in_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
  assign w_accept  = in_valid && in_ready;
  assign w_is_iter = (ALUctrl >= OP_MUL) && (ALUctrl <= OP_REMU);
  assign w_shamt   = ALUop2[SHW-1:0];

  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state == S_BUSY);
  assign ALUout    = r_aluout;
  assign zero      = r_zero;

  // Single-cycle result; undefined encodings (and the iterative ones, which
  // never take this path) yield 0.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    w_single = '0;
    case (ALUctrl)
      OP_ADD:  w_single = ALUop1 + ALUop2;
      OP_SUB:  w_single = ALUop1 - ALUop2;
      OP_AND:  w_single = ALUop1 & ALUop2;
      OP_OR:   w_single = ALUop1 | ALUop2;
      OP_XOR:  w_single = ALUop1 ^ ALUop2;
      OP_SLL:  w_single = ALUop1 << w_shamt;
      OP_SRL:  w_single = ALUop1 >> w_shamt;
      OP_SRA:  w_single = DATA_WIDTH'($signed(ALUop1) >>> w_shamt);
      OP_SLT:  w_single = {{(DATA_WIDTH-1){1'b0}}, ($signed(ALUop1) < $signed(ALUop2))};
      OP_SLTU: w_single = {{(DATA_WIDTH-1){1'b0}}, (ALUop1 < ALUop2)};
      default: w_single = '0;
    endcase
  end

  // One iteration step. Multiply: add the multiplicand into the high half
  // when the current multiplier bit is set, then shift {carry,hi,lo} right.
  // Divide: shift the next dividend bit into the remainder and subtract the
  // divisor when it fits. A zero divisor always "fits", which naturally
  // produces an all-ones quotient and a remainder equal to the dividend.
  assign w_op_is_mul = (r_op == OP_MUL) || (r_op == OP_MULHU);
  assign w_sum       = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : '0);
  assign w_rem_sh    = {r_hi, r_lo[DATA_WIDTH-1]};
  assign w_ge        = (w_rem_sh >= {1'b0, r_m});
  // Only the low bits are kept: when w_ge holds the difference is < r_m.
  assign w_diff      = w_rem_sh[DATA_WIDTH-1:0] - r_m;

  always_comb begin
    w_hi_nx = '0;
    w_lo_nx = '0;
    if (w_op_is_mul) begin
      w_hi_nx = w_sum[DATA_WIDTH:1];
      w_lo_nx = {w_sum[0], r_lo[DATA_WIDTH-1:1]};
    end else begin
      w_hi_nx = w_ge ? w_diff : w_rem_sh[DATA_WIDTH-1:0];
      w_lo_nx = {r_lo[DATA_WIDTH-2:0], w_ge};
    end
  end

  // MUL and DIVU take the low register, MULHU and REMU the high one.
  assign w_iter_res = ((r_op == OP_MUL) || (r_op == OP_DIVU)) ? w_lo_nx : w_hi_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE: if (in_valid) w_state_nx = w_is_iter ? S_BUSY : S_DONE;
      S_BUSY: if (r_cnt == CNT_W'(1)) w_state_nx = S_DONE;
      S_DONE: begin
        if (out_ready) begin
          if (in_valid) w_state_nx = w_is_iter ? S_BUSY : S_DONE;
          else          w_state_nx = S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the iteration registers are reset along with the visible outputs;
    // they are few and a clean reset keeps an aborted operation from leaking.
    if (rst) begin
      r_aluout <= '0;
      r_zero   <= 1'b0;
      r_cnt    <= '0;
      r_op     <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_m      <= '0;
    end else if (w_accept) begin
      if (w_is_iter) begin
        r_op  <= ALUctrl;
        r_hi  <= '0;
        r_lo  <= ALUop1;
        r_m   <= ALUop2;
        r_cnt <= CNT_W'(DATA_WIDTH);
      end else begin
        // NOTE: non-blocking assignments keep every register sampling the
        // pre-edge values, independent of statement order.
        r_aluout <= w_single;
        r_zero   <= (w_single == '0);
      end
    end else if (r_state == S_BUSY) begin
      r_hi  <= w_hi_nx;
      r_lo  <= w_lo_nx;
      r_cnt <= r_cnt - CNT_W'(1);
      if (r_cnt == CNT_W'(1)) begin
        r_aluout <= w_iter_res;
        r_zero   <= (w_iter_res == '0);
      end
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
module tb_alu_mc;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] ALUop1;
  logic [31:0] ALUop2;
  logic [4:0]  ALUctrl;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ALUout;
  logic        zero;
  logic        busy;

  int total = 0;
  int bad   = 0;

  alu_mc #(.DATA_WIDTH(32), .CTRL_WIDTH(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ALUop1    (ALUop1),
    .ALUop2    (ALUop2),
    .ALUctrl   (ALUctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ALUout    (ALUout),
    .zero      (zero),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model written straight from the operation definitions.
  function automatic logic [31:0] ref_alu(input logic [4:0] c, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] p;
    int unsigned sh;
    p  = 64'(a) * 64'(b);
    sh = b % 32;
    case (c)
      5'd0:    return a + b;
      5'd1:    return a - b;
      5'd2:    return a & b;
      5'd3:    return a | b;
      5'd4:    return a ^ b;
      5'd5:    return a << sh;
      5'd6:    return a >> sh;
      5'd7:    return 32'($signed(a) >>> sh);
      5'd8:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5'd9:    return (a < b) ? 32'd1 : 32'd0;
      5'd10:   return p[31:0];
      5'd11:   return p[63:32];
      5'd12:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      5'd13:   return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  // Called at a negedge with the block idle. Issues one op, measures the
  // number of edges from accept to out_valid, checks result/zero/latency,
  // and optionally consumes the result.
  task automatic run_op(input string tag, input logic [4:0] c, input logic [31:0] a,
                        input logic [31:0] b, input bit consume);
    logic [31:0] exp;
    int          lat;
    int          n;
    exp = ref_alu(c, a, b);
    lat = (c >= 5'd10 && c <= 5'd13) ? 32 : 0;
    ALUctrl  = c;
    ALUop1   = a;
    ALUop2   = b;
    in_valid = 1'b1;
    check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    if (lat != 0) begin
      check({tag, ".busy"}, 32'(busy), 32'd1);
      // Scrambled inputs while busy must have no effect.
      ALUop1  = $urandom;
      ALUop2  = $urandom;
      ALUctrl = 5'($urandom_range(0, 15));
    end else begin
      in_valid = 1'b0;
    end
    n = 0;
    while (out_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    check({tag, ".latency"}, 32'(n), 32'(lat));
    check({tag, ".result"}, ALUout, exp);
    check({tag, ".zero"}, 32'(zero), 32'(exp == 0));
    if (lat != 0) check({tag, ".busy_done"}, 32'(busy), 32'd0);
    if (consume) begin
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, ".drained"}, 32'(out_valid), 32'd0);
    end
  endtask

  initial begin
    logic [4:0]  bb_c [4];
    logic [31:0] bb_a [4];
    logic [31:0] bb_b [4];
    logic [31:0] held;
    logic [4:0]  rc;
    logic [31:0] ra;
    logic [31:0] rb;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    ALUop1 = '0; ALUop2 = '0; ALUctrl = '0;
    #1;
    check("rst.ALUout", ALUout, 32'd0);
    check("rst.zero", 32'(zero), 32'd0);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst.in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);

    run_op("add5_7", 5'd0, 32'd5, 32'd7, 1'b1);
    check("add5_7.const", ALUout, 32'd12);
    run_op("sub7_7", 5'd1, 32'd7, 32'd7, 1'b1);
    check("sub7_7.zero_const", 32'(zero), 32'd1);

    // Back-to-back single-cycle ops, one result per cycle.
    bb_c = '{5'd2, 5'd3, 5'd4, 5'd7};
    bb_a = '{32'h0000_F0F0, 32'h0000_F0F0, 32'h0000_F0F0, 32'h8000_0000};
    bb_b = '{32'h0000_FF00, 32'h0000_FF00, 32'h0000_FF00, 32'd4};
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ALUctrl = bb_c[i]; ALUop1 = bb_a[i]; ALUop2 = bb_b[i];
      @(posedge clk);
      @(negedge clk);
      check($sformatf("b2b%0d.out_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("b2b%0d.result", i), ALUout, ref_alu(bb_c[i], bb_a[i], bb_b[i]));
      check($sformatf("b2b%0d.in_ready", i), 32'(in_ready), 32'd1);
    end
    check("b2b.sra_const", ALUout, 32'hF800_0000);
    in_valid = 1'b0;
    @(negedge clk);
    check("b2b.idle", 32'(out_valid), 32'd0);
    check("b2b.keep", ALUout, 32'hF800_0000);
    out_ready = 1'b0;

    run_op("mul", 5'd10, 32'hFFFF_FFFF, 32'd2, 1'b1);
    check("mul.const", ALUout, 32'hFFFF_FFFE);
    run_op("mulhu", 5'd11, 32'hFFFF_FFFF, 32'd2, 1'b1);
    check("mulhu.const", ALUout, 32'd1);
    run_op("divu", 5'd12, 32'd100, 32'd7, 1'b1);
    check("divu.const", ALUout, 32'd14);
    run_op("remu", 5'd13, 32'd100, 32'd7, 1'b1);
    check("remu.const", ALUout, 32'd2);
    run_op("divu0", 5'd12, 32'd5, 32'd0, 1'b1);
    check("divu0.const", ALUout, 32'hFFFF_FFFF);
    run_op("remu0", 5'd13, 32'd5, 32'd0, 1'b1);
    check("remu0.const", ALUout, 32'd5);

    // Result held with out_ready low; new requests must not be accepted.
    run_op("hold", 5'd0, 32'h0000_1234, 32'd1, 1'b0);
    held = 32'h0000_1235;
    ALUctrl = 5'd1; ALUop1 = 32'd9; ALUop2 = 32'd9; in_valid = 1'b1;
    check("hold.in_ready0", 32'(in_ready), 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("hold%0d.ALUout", i), ALUout, held);
      check($sformatf("hold%0d.out_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("hold%0d.in_ready", i), 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("hold.drained", 32'(out_valid), 32'd0);
    check("hold.keep", ALUout, held);

    // Asynchronous reset in the middle of a divide.
    ALUctrl = 5'd12; ALUop1 = 32'd1000; ALUop2 = 32'd3; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (14) @(negedge clk);
    check("abort.busy_before", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("abort.ALUout", ALUout, 32'd0);
    check("abort.zero", 32'(zero), 32'd0);
    check("abort.out_valid", 32'(out_valid), 32'd0);
    check("abort.busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort.in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    run_op("post_rst_add", 5'd0, 32'd40, 32'd2, 1'b1);

    // Randomized ops, including undefined encodings and zero divisors.
    for (int i = 0; i < 40; i++) begin
      rc = 5'($urandom_range(0, 15));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'($urandom_range(0, 15));
        default: rb = $urandom;
      endcase
      run_op($sformatf("rand%0d_op%0d", i, rc), rc, ra, rb, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised multi-cycle ALU for the RISC-V datapath, extending the single-cycle add/sub/and/or unit.
- Adds shifts, compares and XOR, each with one-cycle registered latency.
- Adds iterative unsigned multiply (shift-add) and divide/remainder (restoring), each taking DATA_WIDTH cycles.
- Operands enter and results leave through valid/ready handshakes, so the block can stall the execute stage.

Parameters:
- DATA_WIDTH, 32: operand/result width; must be ≥4 and a power of two.
- CTRL_WIDTH, 5: ALUctrl width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands and ALUctrl are valid.
- in_ready  out  1  block accepts a new operation this cycle.
- ALUop1  in  DATA_WIDTH  operand 1.
- ALUop2  in  DATA_WIDTH  operand 2.
- ALUctrl  in  CTRL_WIDTH  operation select.
- out_valid  out  1  ALUout and zero are valid.
- out_ready  in  1  consumer takes the result.
- ALUout  out  DATA_WIDTH  registered result.
- zero  out  1  high when ALUout == 0; registered with ALUout.
- busy  out  1  an iterative operation is in progress.

Behaviour:
- Reset (async, active-high): state=IDLE; ALUout=0; zero=0; out_valid=0; busy=0; iteration counter=0. in_ready=1 as soon as rst deasserts.
- Reset mid-operation aborts the operation and discards its result.
- States:
  - IDLE: no result held.
  - BUSY: iterative operation running.
  - DONE: result held, out_valid=1.
- in_ready = (state==IDLE) or (state==DONE and out_ready). An operation is accepted at an edge where in_valid and in_ready are both high.
- Single-cycle encodings (0-9, result computed combinationally and registered at the accept edge; state→DONE):
  - 0 ADD
  - 1 SUB
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 SLL
  - 6 SRL
  - 7 SRA
  - 8 SLT (signed; result 1/0)
  - 9 SLTU (unsigned)
- Undefined encodings (14..2^CTRL_WIDTH-1) behave as single-cycle with result 0.
- Shift amount = ALUop2[log2(DATA_WIDTH)-1:0]; upper bits are ignored.
- Arithmetic wraps modulo 2^DATA_WIDTH; there is no overflow flag.
- Iterative encodings:
  - 10 MUL: low DATA_WIDTH bits of the unsigned product.
  - 11 MULHU: high DATA_WIDTH bits of the unsigned product.
  - 12 DIVU: unsigned quotient.
  - 13 REMU: unsigned remainder.
- Iterative sequence:
  - At the accept edge, operands latch into internal registers, counter=DATA_WIDTH, state→BUSY, busy=1.
  - Each BUSY edge performs one step and decrements the counter.
  - At the edge where the counter reaches 0, the result is registered, state→DONE, busy=0.
  - out_valid therefore rises DATA_WIDTH edges after the accept edge.
- Divide by zero: DIVU returns all-ones; REMU returns ALUop1. It still takes the full DATA_WIDTH cycles, for deterministic latency.
- Inputs are ignored while BUSY (in_ready=0). Changing ALUop1/ALUop2/ALUctrl during BUSY has no effect.
- DONE with out_ready=0: ALUout, zero and out_valid hold indefinitely.
- DONE with out_ready=1 and no new accept: state→IDLE, out_valid=0. ALUout keeps its last value.
- DONE with out_ready=1 and a simultaneous accept:
  - Single-cycle op: new result registered, out_valid stays 1 (back-to-back, one result per cycle).
  - Iterative op: state→BUSY, out_valid=0.
- zero is updated only when ALUout is updated.

Test Plan:
- Reset, then ADD 5+7: accept at edge 0 → ALUout=12, zero=0, out_valid=1 after edge 0. SUB 7-7 → ALUout=0, zero=1.
- Hold out_ready=1 with in_valid=1 for 4 consecutive ops (AND 0xF0F0&0xFF00, OR, XOR, SRA 0x80000000>>4) → results 0xF000, …, 0xF8000000 on consecutive cycles with no bubbles.
- MUL 0xFFFFFFFF*2 → out_valid exactly 32 edges after accept; ALUout=0xFFFFFFFE. MULHU with the same operands → 0x00000001. busy=1 throughout BUSY.
- DIVU 100/7 → 14; REMU 100/7 → 2; DIVU 5/0 → 0xFFFFFFFF; REMU 5/0 → 5. Each takes 32 cycles.
- out_ready held 0 for 10 cycles after a result → ALUout and out_valid stable, in_ready=0; a new in_valid during this time is not accepted.
- Assert rst at cycle 15 of a DIVU → all outputs 0 immediately (async). After release, in_ready=1 and an ADD completes normally.
